// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and datapath width, common to the
// transmitter and receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO for the UART transmitter; head entry is visible
// combinationally on rd_data.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_wr, do_rd;

    // DEPTH is a power of two, so the top level bit alone marks full.
    assign full    = level_q[AW];
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB-first, optional parity, 1 or 2 stop bits,
// one bit per baud_clk_en strobe, fed from a small byte FIFO.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_clk_en,
    input  logic [UART_DATA_W-1:0]        tx_data,
    input  logic                          tx_data_valid,
    output logic                          tx_ready,
    output logic                          tx_out,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    uart_state_e            state_q, state_d;
    logic [UART_DATA_W-1:0] shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   load;
    logic                   fifo_rd, fifo_full, fifo_empty;
    logic [UART_DATA_W-1:0] fifo_rdata;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_data_valid),
        .wr_data (tx_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        load       = 1'b0;
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (baud_clk_en && !fifo_empty) load = 1'b1;
            end
            StStart: begin
                if (baud_clk_en) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (baud_clk_en) begin
                    if (bit_cnt_q == 3'd7) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY_EN) begin
                            tx_d    = parity_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (baud_clk_en) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
            end
            StStop: begin
                if (baud_clk_en) begin
                    if (32'(stop_cnt_q) < STOP_BITS - 1) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Pop the head byte and start the next frame; parity is latched here.
        if (load) begin
            shift_d  = fifo_rdata;
            parity_d = (^fifo_rdata) ^ PARITY_ODD;
            tx_d     = 1'b0;
            state_d  = StStart;
        end
    end

    assign fifo_rd = load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_out   = tx_q;
    assign tx_busy  = (state_q != StIdle);
    assign tx_ready = !fifo_full;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: three instances (8N1, 8O2, 8E1)
// with a byte scoreboard checked bit-by-bit on the serial line.
module tb_uart_transmitter;

    logic       clk;
    logic       rst_n;
    logic       baud_clk_en;
    logic [7:0] tx_data;
    logic       v0, v1, v2;
    logic       tx_ready0, tx_ready1, tx_ready2;
    logic       tx_out0, tx_out1, tx_out2;
    logic       tx_busy0, tx_busy1, tx_busy2;
    logic [2:0] lvl0, lvl1, lvl2;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mon_sel  = 0;
    int         div      = 0;
    bit         baud_run = 1'b0;
    logic [7:0] sb_q [$];

    logic       line, busy;
    logic [2:0] lvl;

    uart_transmitter #(
        .FIFO_DEPTH (4), .PARITY_EN (1'b0), .PARITY_ODD (1'b0), .STOP_BITS (1)
    ) dut (
        .clk (clk), .rst_n (rst_n), .baud_clk_en (baud_clk_en), .tx_data (tx_data),
        .tx_data_valid (v0), .tx_ready (tx_ready0), .tx_out (tx_out0),
        .tx_busy (tx_busy0), .fifo_level (lvl0)
    );

    uart_transmitter #(
        .FIFO_DEPTH (4), .PARITY_EN (1'b1), .PARITY_ODD (1'b1), .STOP_BITS (2)
    ) dut_odd2 (
        .clk (clk), .rst_n (rst_n), .baud_clk_en (baud_clk_en), .tx_data (tx_data),
        .tx_data_valid (v1), .tx_ready (tx_ready1), .tx_out (tx_out1),
        .tx_busy (tx_busy1), .fifo_level (lvl1)
    );

    uart_transmitter #(
        .FIFO_DEPTH (4), .PARITY_EN (1'b1), .PARITY_ODD (1'b0), .STOP_BITS (1)
    ) dut_even1 (
        .clk (clk), .rst_n (rst_n), .baud_clk_en (baud_clk_en), .tx_data (tx_data),
        .tx_data_valid (v2), .tx_ready (tx_ready2), .tx_out (tx_out2),
        .tx_busy (tx_busy2), .fifo_level (lvl2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        line = tx_out0;
        busy = tx_busy0;
        lvl  = lvl0;
        case (mon_sel)
            1:       begin line = tx_out1; busy = tx_busy1; lvl = lvl1; end
            2:       begin line = tx_out2; busy = tx_busy2; lvl = lvl2; end
            default: begin line = tx_out0; busy = tx_busy0; lvl = lvl0; end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; afterwards outputs are sampled and the strobe for the next edge is set.
    task automatic step();
        @(posedge clk);
        #1;
        if (baud_run) begin
            div         = (div == 15) ? 0 : div + 1;
            baud_clk_en = (div == 15);
        end else begin
            div         = 0;
            baud_clk_en = 1'b0;
        end
    endtask

    task automatic baud_off();
        baud_run    = 1'b0;
        baud_clk_en = 1'b0;
        div         = 0;
    endtask

    // Advance through the next enabled edge, optionally pushing into dut on that edge.
    task automatic wait_enable(input bit do_push, input logic [7:0] d);
        int n = 0;
        while (baud_clk_en !== 1'b1 && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) begin
            n_checks++;
            n_fail++;
            $error("FAIL baud_timeout: observed no strobe expected strobe within 64 clk");
        end
        if (do_push) begin
            tx_data = d;
            v0      = 1'b1;
            sb_q.push_back(d);
        end
        step();
        v0 = 1'b0;
    endtask

    task automatic push(input int sel, input logic [7:0] d, input bit accept);
        logic rdy;
        rdy = (sel == 0) ? tx_ready0 : (sel == 1) ? tx_ready1 : tx_ready2;
        chk("tx_ready_before_push", rdy, accept);
        tx_data = d;
        case (sel)
            0:       v0 = 1'b1;
            1:       v1 = 1'b1;
            default: v2 = 1'b1;
        endcase
        if (accept) sb_q.push_back(d);
        step();
        v0 = 1'b0;
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    // Pops one byte from the scoreboard and checks every bit period of its frame.
    task automatic check_frame(input bit par_en, input bit odd, input int stops,
                               input bit push_mid, input logic [7:0] push_d);
        logic [7:0] b;
        bit         exp_bits [$];
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected at least 1");
            return;
        end
        b = sb_q.pop_front();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        if (par_en) exp_bits.push_back((^b) ^ odd);
        for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
        for (int k = 0; k < exp_bits.size(); k++) begin
            wait_enable(push_mid && k == 0, push_d);
            chk($sformatf("line_byte%02h_bit%0d", b, k), line, exp_bits[k]);
            chk($sformatf("busy_byte%02h_bit%0d", b, k), busy, 1);
            if (push_mid && k == 0) chk("level_push_pop_same_cycle", lvl, 2);
        end
    endtask

    task automatic check_idle_after(input string tag);
        wait_enable(1'b0, 8'h00);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_line"}, line, 1);
        chk({tag, "_level"}, lvl, 0);
    endtask

    initial begin
        logic [7:0] v;
        rst_n       = 1'b0;
        baud_clk_en = 1'b0;
        tx_data     = 8'h00;
        v0          = 1'b0;
        v1          = 1'b0;
        v2          = 1'b0;
        step();
        step();
        chk("reset_tx_out", tx_out0, 1);
        chk("reset_tx_busy", tx_busy0, 0);
        chk("reset_tx_ready", tx_ready0, 1);
        chk("reset_level", lvl0, 0);
        rst_n = 1'b1;
        step();

        // 8N1 single byte
        baud_run = 1'b1;
        mon_sel  = 0;
        push(0, 8'h41, 1'b1);
        check_frame(1'b0, 1'b0, 1, 1'b0, 8'h00);
        check_idle_after("after_0x41");

        // Four back-to-back frames, no idle gap
        baud_off();
        push(0, 8'h55, 1'b1);
        push(0, 8'hAA, 1'b1);
        push(0, 8'h0F, 1'b1);
        push(0, 8'hF0, 1'b1);
        chk("burst_level_peak", lvl0, 4);
        chk("burst_ready_full", tx_ready0, 0);
        baud_run = 1'b1;
        for (int f = 0; f < 4; f++) check_frame(1'b0, 1'b0, 1, 1'b0, 8'h00);
        check_idle_after("after_burst");

        // Overfill with strobe held low: fifth byte dropped
        baud_off();
        push(0, 8'h11, 1'b1);
        push(0, 8'h22, 1'b1);
        push(0, 8'h33, 1'b1);
        push(0, 8'h44, 1'b1);
        push(0, 8'h99, 1'b0);
        repeat (20) step();
        chk("overfill_level", lvl0, 4);
        chk("overfill_line_frozen", tx_out0, 1);
        chk("overfill_busy_frozen", tx_busy0, 0);
        baud_run = 1'b1;
        for (int f = 0; f < 4; f++) check_frame(1'b0, 1'b0, 1, 1'b0, 8'h00);
        check_idle_after("after_overfill");
        wait_enable(1'b0, 8'h00);
        chk("no_fifth_frame_line", line, 1);
        chk("no_fifth_frame_busy", busy, 0);

        // Odd parity, two stop bits
        mon_sel = 1;
        push(1, 8'h41, 1'b1);
        check_frame(1'b1, 1'b1, 2, 1'b0, 8'h00);
        check_idle_after("after_odd2");

        // Even parity, one stop bit
        mon_sel = 2;
        push(2, 8'h41, 1'b1);
        check_frame(1'b1, 1'b0, 1, 1'b0, 8'h00);
        check_idle_after("after_even1");

        // Push on the same edge as the STOP_BIT pop with two bytes queued
        mon_sel = 0;
        baud_off();
        push(0, 8'h12, 1'b1);
        push(0, 8'h34, 1'b1);
        push(0, 8'h56, 1'b1);
        baud_run = 1'b1;
        check_frame(1'b0, 1'b0, 1, 1'b0, 8'h00);
        check_frame(1'b0, 1'b0, 1, 1'b1, 8'h78);
        check_frame(1'b0, 1'b0, 1, 1'b0, 8'h00);
        check_frame(1'b0, 1'b0, 1, 1'b0, 8'h00);
        check_idle_after("after_simul");

        // Reset during data bit 3 with two bytes still queued
        baud_off();
        push(0, 8'h41, 1'b1);
        push(0, 8'h42, 1'b1);
        push(0, 8'h43, 1'b1);
        baud_run = 1'b1;
        v = 8'h41;
        for (int i = 0; i < 5; i++) begin
            wait_enable(1'b0, 8'h00);
            chk($sformatf("pre_reset_bit%0d", i), line, (i == 0) ? 1'b0 : v[i-1]);
        end
        chk("pre_reset_level", lvl0, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_tx_out", tx_out0, 1);
        chk("midframe_reset_busy", tx_busy0, 0);
        chk("midframe_reset_level", lvl0, 0);
        chk("midframe_reset_ready", tx_ready0, 1);
        sb_q.delete();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_enable(1'b0, 8'h00);
            chk($sformatf("post_reset_line_%0d", i), line, 1);
            chk($sformatf("post_reset_busy_%0d", i), busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
